design_controller_01: RTL and testbench
=======================================

DESIGN_CONTROLLER_01 -- requirements
Module: design_controller_01

Interface
REQ-001 Parameter SENSE_CYCLES, default 2: consecutive cycles sense must be sampled high before the motor starts; legal range 1..15.
REQ-002 Parameter MAX_RUN_CYCLES, default 16: maximum consecutive RUN cycles before lockout; legal range 2..255.
REQ-003 Port clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on the rising clock edge.
REQ-005 Port button  input  1  operator run request, level-sensitive, 1 = held.
REQ-006 Port sense  input  1  engine-ready sensor, 1 = ready.
REQ-007 Port enable  output  1  controller armed or running.
REQ-008 Port motor  output  1  motor drive, 1 = on.
REQ-009 There shall be one clock and a synchronous, active-high reset.

Function
REQ-010 The FSM shall have four states:
- IDLE: enable=0, motor=0.
- ARM: enable=1, motor=0.
- RUN: enable=1, motor=1.
- BAN: enable=0, motor=0.
REQ-011 Outputs shall be decoded from the state register only (Moore), so an output changes in the same edge that enters the new state.
REQ-012 IDLE: button=1 -> ARM on the next edge; otherwise stay in IDLE.
REQ-013 ARM: button=0 -> IDLE; otherwise count consecutive sense=1 samples.
- A sense=0 sample clears the count.
- The count reaching SENSE_CYCLES -> RUN.
REQ-014 The sense count shall be cleared on every entry to ARM.
REQ-015 RUN shall increment an 8-bit run counter each cycle; the counter shall be cleared on RUN entry.
REQ-016 RUN transition priority:
- button=0 -> IDLE;
- else run counter = MAX_RUN_CYCLES-1 -> BAN;
- else sense=0 -> ARM.
REQ-017 BAN: stay until button=0 and sense=0 are sampled in the same cycle -> IDLE; button alone shall not leave BAN.
REQ-018 Counters shall saturate and never wrap.
REQ-019 Unreachable state encodings shall return to IDLE on the next edge.

Reset
REQ-020 reset=1 at an edge shall force IDLE, clear both counters, and give enable=0, motor=0 after that edge, overriding all inputs.
REQ-021 Reset asserted mid-RUN or in BAN shall take effect on the same edge; release resumes from IDLE evaluating current inputs on the following edge.
REQ-022 Held reset of any length shall keep outputs at 0.

Configuration
REQ-023 With macro DC01_INPUT_SYNC_EN defined:
- button and sense shall each pass through a 2-flop synchronizer before the FSM;
- this adds exactly 2 cycles of input-to-output latency;
- the synchronizer flops shall reset to 0.
REQ-024 Without DC01_INPUT_SYNC_EN, the FSM shall sample raw inputs directly; latency from an input change to an output change is one edge.

Structure
REQ-025 Package design_controller_01_pkg shall hold:
- the state enum (IDLE, ARM, RUN, BAN);
- default constants for SENSE_CYCLES and MAX_RUN_CYCLES;
- the counter widths.
REQ-026 Sub-module dc01_sync2 (2-flop synchronizer, synchronous reset) shall be instantiated only under DC01_INPUT_SYNC_EN; everything else shall be flat in design_controller_01.

Verification (defaults, macro off)
REQ-027 Reset 2 cycles, then button=1 -> enable=1 after first edge; sense=1 held -> motor=1 after the 2nd edge with sense high (edge 3 from button).
REQ-028 In RUN, sense=0 -> next edge: motor=0, enable=1 (ARM); sense back high for 2 cycles -> motor=1 again.
REQ-029 In RUN, button=0 and sense=0 simultaneously -> IDLE (button priority), enable=0, motor=0 after one edge.
REQ-030 Hold button=1, sense=1 for 20 cycles -> motor high exactly 16 cycles, then BAN (enable=0, motor=0).
- Releasing button only keeps BAN.
- Then sense=0 -> IDLE.
REQ-031 Reset asserted for 1 cycle mid-RUN -> enable=0, motor=0 after that edge.
- With button=1 at release, ARM is re-entered one edge after release.
REQ-032 With DC01_INPUT_SYNC_EN, repeat REQ-027 -> each output transition delayed by exactly 2 cycles.

Source files
------------

// File: rtl/design_controller_01_pkg.sv
// rtl/design_controller_01_pkg.sv - shared state type, defaults and counter widths for design_controller_01
package design_controller_01_pkg;

  // Controller states; every 2-bit encoding is a named state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    BAN  = 2'd3
  } dc01_state_t;

  // Default configuration values.
  localparam int SENSE_CYCLES_DEF   = 2;
  localparam int MAX_RUN_CYCLES_DEF = 16;

  // Counter widths: sense streak covers 1..15, run counter covers 2..255.
  localparam int SENSE_CNT_W = 4;
  localparam int RUN_CNT_W   = 8;

  // Saturating increment for the sense streak counter.
  function automatic logic [SENSE_CNT_W-1:0] sense_inc(input logic [SENSE_CNT_W-1:0] v);
    if (v == {SENSE_CNT_W{1'b1}}) begin
      return v;
    end
    return v + SENSE_CNT_W'(1);
  endfunction

  // Saturating increment for the run-length counter.
  function automatic logic [RUN_CNT_W-1:0] run_inc(input logic [RUN_CNT_W-1:0] v);
    if (v == {RUN_CNT_W{1'b1}}) begin
      return v;
    end
    return v + RUN_CNT_W'(1);
  endfunction

endpackage

// File: rtl/dc01_sync2.sv
// rtl/dc01_sync2.sv - two-flop synchronizer with synchronous active-high reset to 0
module dc01_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both clear to 0 on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/design_controller_01.sv
// rtl/design_controller_01.sv - motor start/run/lockout controller; DC01_INPUT_SYNC_EN adds 2-flop input synchronizers
module design_controller_01
  import design_controller_01_pkg::*;
#(
  parameter int SENSE_CYCLES   = SENSE_CYCLES_DEF,
  parameter int MAX_RUN_CYCLES = MAX_RUN_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  input  logic sense,
  output logic enable,
  output logic motor
);

  // Comparison points: last streak value before RUN, last run count before BAN.
  localparam logic [SENSE_CNT_W-1:0] SENSE_LAST = SENSE_CNT_W'(SENSE_CYCLES - 1);
  localparam logic [RUN_CNT_W-1:0]   RUN_LAST   = RUN_CNT_W'(MAX_RUN_CYCLES - 1);

  logic btn_f;
  logic sns_f;

  dc01_state_t             state;
  dc01_state_t             state_nx;
  logic [SENSE_CNT_W-1:0]  sense_cnt;
  logic [SENSE_CNT_W-1:0]  sense_cnt_nx;
  logic [RUN_CNT_W-1:0]    run_cnt;
  logic [RUN_CNT_W-1:0]    run_cnt_nx;

`ifdef DC01_INPUT_SYNC_EN
  dc01_sync2 u_sync_button (
    .clock (clock),
    .reset (reset),
    .d     (button),
    .q     (btn_f)
  );

  dc01_sync2 u_sync_sense (
    .clock (clock),
    .reset (reset),
    .d     (sense),
    .q     (sns_f)
  );
`else
  assign btn_f = button;
  assign sns_f = sense;
`endif

  // State and counter registers; reset forces IDLE with both counters cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      sense_cnt <= '0;
      run_cnt   <= '0;
    end else begin
      state     <= state_nx;
      sense_cnt <= sense_cnt_nx;
      run_cnt   <= run_cnt_nx;
    end
  end

  // Next-state logic; counters default to 0 so every state entry starts them cleared.
  always_comb begin
    state_nx     = state;
    sense_cnt_nx = '0;
    run_cnt_nx   = '0;
    case (state)
      IDLE: begin
        if (btn_f) begin
          state_nx = ARM;
        end
      end
      ARM: begin
        if (!btn_f) begin
          state_nx = IDLE;
        end else if (sns_f) begin
          if (sense_cnt == SENSE_LAST) begin
            state_nx = RUN;
          end else begin
            sense_cnt_nx = sense_inc(sense_cnt);
          end
        end
      end
      RUN: begin
        if (!btn_f) begin
          state_nx = IDLE;
        end else if (run_cnt == RUN_LAST) begin
          state_nx = BAN;
        end else if (!sns_f) begin
          state_nx = ARM;
        end else begin
          run_cnt_nx = run_inc(run_cnt);
        end
      end
      BAN: begin
        if (!btn_f && !sns_f) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Moore output decode from the state register only.
  always_comb begin
    enable = 1'b0;
    motor  = 1'b0;
    case (state)
      ARM: begin
        enable = 1'b1;
      end
      RUN: begin
        enable = 1'b1;
        motor  = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_design_controller_01.sv
// tb/tb_design_controller_01.sv - directed and randomized self-checking bench for design_controller_01
module tb_design_controller_01;

  localparam int SENSE   = 2;
  localparam int MAX_RUN = 16;

  logic clock;
  logic reset;
  logic button;
  logic sense;
  logic enable;
  logic motor;

  int checks = 0;
  int errors = 0;

  // Behavioural model: operator-level flags and plain integer counts.
  bit       armed;
  bit       running;
  bit       banned;
  int       streak;
  int       runlen;
  logic [1:0] pb;
  logic [1:0] ps;

  design_controller_01 #(
    .SENSE_CYCLES   (SENSE),
    .MAX_RUN_CYCLES (MAX_RUN)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .button (button),
    .sense  (sense),
    .enable (enable),
    .motor  (motor)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply one rising edge to the model with the inputs sampled at that edge.
  task automatic model_edge(input logic r, input logic b, input logic s);
    logic fb;
    logic fs;
`ifdef DC01_INPUT_SYNC_EN
    fb = pb[1];
    fs = ps[1];
    if (r) begin
      pb = 2'b00;
      ps = 2'b00;
    end else begin
      pb = {pb[0], b};
      ps = {ps[0], s};
    end
`else
    fb = b;
    fs = s;
`endif
    if (r) begin
      armed = 0; running = 0; banned = 0; streak = 0; runlen = 0;
    end else if (banned) begin
      if (!fb && !fs) banned = 0;
    end else if (!fb) begin
      armed = 0; running = 0;
    end else if (running) begin
      runlen++;
      if (runlen >= MAX_RUN) begin
        running = 0; banned = 1;
      end else if (!fs) begin
        running = 0; armed = 1; streak = 0;
      end
    end else if (armed) begin
      streak = fs ? streak + 1 : 0;
      if (streak >= SENSE) begin
        armed = 0; running = 1; runlen = 0;
      end
    end else begin
      armed = 1; streak = 0;
    end
  endtask

  task automatic tick(input logic r, input logic b, input logic s);
    reset  = r;
    button = b;
    sense  = s;
    @(posedge clock);
    model_edge(r, b, s);
    #1;
  endtask

  initial begin
    int motor_cycles;
    logic rb, rs, rr;
    reset = 1'b1; button = 1'b0; sense = 1'b0;
    armed = 0; running = 0; banned = 0; streak = 0; runlen = 0;
    pb = 2'b00; ps = 2'b00;

    tick(1, 0, 0);
    tick(1, 0, 0);
    check("reset_enable", enable, 1'b0);
    check("reset_motor", motor, 1'b0);

`ifndef DC01_INPUT_SYNC_EN
    // Start sequence: ARM after one edge, RUN on the 3rd edge.
    tick(0, 1, 1);
    check("start_e1_enable", enable, 1'b1);
    check("start_e1_motor", motor, 1'b0);
    tick(0, 1, 1);
    check("start_e2_motor", motor, 1'b0);
    tick(0, 1, 1);
    check("start_e3_motor", motor, 1'b1);

    // Sense drop falls back to ARM, two high samples restart.
    tick(0, 1, 0);
    check("sense_drop_enable", enable, 1'b1);
    check("sense_drop_motor", motor, 1'b0);
    tick(0, 1, 1);
    check("rearm_e1_motor", motor, 1'b0);
    tick(0, 1, 1);
    check("rearm_e2_motor", motor, 1'b1);

    // Button release has priority over sense drop.
    tick(0, 0, 0);
    check("release_enable", enable, 1'b0);
    check("release_motor", motor, 1'b0);

    // Lockout after MAX_RUN consecutive run cycles.
    motor_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, 1);
      if (motor) motor_cycles++;
    end
    checks++;
    assert (motor_cycles === MAX_RUN) else begin
      errors++;
      $error("FAIL lockout_motor_cycles observed=%0d expected=%0d", motor_cycles, MAX_RUN);
    end
    check("ban_enable", enable, 1'b0);
    check("ban_motor", motor, 1'b0);
    tick(0, 0, 1);
    tick(0, 1, 1);
    check("ban_hold_enable", enable, 1'b0);
    tick(0, 0, 0);
    check("ban_exit_enable", enable, 1'b0);
    tick(0, 1, 0);
    check("after_ban_arm_enable", enable, 1'b1);

    // Reset mid-RUN, then re-arm one edge after release.
    tick(0, 1, 1);
    tick(0, 1, 1);
    check("run_again_motor", motor, 1'b1);
    tick(1, 1, 1);
    check("midrun_reset_enable", enable, 1'b0);
    check("midrun_reset_motor", motor, 1'b0);
    tick(0, 1, 1);
    check("post_reset_enable", enable, 1'b1);
    check("post_reset_motor", motor, 1'b0);
`else
    // Synchronized inputs: every transition two edges later.
    tick(0, 1, 1);
    check("sync_e1_enable", enable, 1'b0);
    tick(0, 1, 1);
    check("sync_e2_enable", enable, 1'b0);
    tick(0, 1, 1);
    check("sync_e3_enable", enable, 1'b1);
    tick(0, 1, 1);
    check("sync_e4_motor", motor, 1'b0);
    tick(0, 1, 1);
    check("sync_e5_motor", motor, 1'b1);
`endif

    // Held reset keeps outputs low regardless of inputs.
    for (int i = 0; i < 6; i++) begin
      tick(1, 1, 1);
      check("held_reset_enable", enable, 1'b0);
      check("held_reset_motor", motor, 1'b0);
    end

    // Randomized stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 63) == 0);
      rb = ($urandom_range(0, 99) < 85);
      rs = ($urandom_range(0, 99) < 80);
      if ($urandom_range(0, 19) == 0) begin
        rb = 1'b0;
        rs = 1'b0;
      end
      tick(rr, rb, rs);
      check("rand_enable", enable, logic'(armed | running));
      check("rand_motor", motor, logic'(running));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
